// File: rtl/conv_stream_feeder_if.sv
// Source-memory read port plus the outgoing beat stream of the convolution feeder.
// The master side belongs to the feeder; the slave side is the memory/consumer environment.
interface conv_stream_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
);
  logic                  src_re;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [DATA_WIDTH-1:0] src_rdata;
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  beat_is_weight;
  logic                  beat_half;

  modport master (
    output src_re, src_addr,
    input  src_rdata,
    output valid, data_out, beat_is_weight, beat_half,
    input  ready
  );

  modport slave (
    input  src_re, src_addr,
    output src_rdata,
    input  valid, data_out, beat_is_weight, beat_half,
    output ready
  );
endinterface

// File: rtl/conv_stream_feeder.sv
// Walks channels/pixels, reads weight and feature word pairs from memory and
// streams them through a 2-entry skid buffer with valid/ready flow control.
module conv_stream_feeder #(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int DATA_WIDTH         = 16,
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int WEIGHT_BASE        = 0
) (
  input  logic clk,
  input  logic rst_in,
  input  logic start,
  output logic running,
  output logic done,
  conv_stream_feeder_if.master bus
);

  localparam int AW = LOG2_OF_MEM_HEIGHT;
  localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int IW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
  localparam int OW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(INPUT_NB_CHANNELS - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUTPUT_NB_CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM_F,
    DRAIN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic          r_k;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [IW-1:0] r_ci;
  logic [OW-1:0] r_co;

  logic r_inFlight;
  logic r_inFlightWeight;
  logic r_inFlightHalf;

  logic [DATA_WIDTH-1:0] r_data [2];
  logic                  r_tagW [2];
  logic                  r_tagH [2];
  logic                  r_wrPtr;
  logic                  r_rdPtr;
  logic [1:0]            r_count;

  logic          w_pop;
  logic [2:0]    w_load;
  logic          w_credit;
  logic          w_issueState;
  logic          w_re;
  logic          w_isWeight;
  logic          w_groupEnd;
  logic          w_lastGroup;
  logic [AW-1:0] w_wAddr;
  logic [AW-1:0] w_fAddr;

  // A read may only be issued if its word is guaranteed a FIFO slot on return.
  assign w_pop    = (r_count != 2'd0) && bus.ready;
  assign w_load   = {1'b0, r_count} + {2'b00, r_inFlight} - {2'b00, w_pop};
  assign w_credit = (w_load < 3'd2);

  // The first weight read goes out in the start cycle so data is valid two cycles later.
  assign w_issueState = ((r_state == IDLE) && start) || (r_state == LOAD_W) || (r_state == STREAM_F);
  assign w_re         = w_issueState && w_credit;
  assign w_isWeight   = (r_state != STREAM_F);
  assign w_groupEnd   = r_k && (r_y == Y_LAST) && (r_x == X_LAST);
  assign w_lastGroup  = (r_co == O_LAST) && (r_ci == I_LAST);

  assign w_wAddr = AW'(WEIGHT_BASE)
                 + ((AW'(r_co) * AW'(INPUT_NB_CHANNELS) + AW'(r_ci)) << 1)
                 + AW'(r_k);
  assign w_fAddr = ((((AW'(r_ci) * AW'(FEATURE_MAP_HEIGHT)) + AW'(r_y)) * AW'(FEATURE_MAP_WIDTH)
                   + AW'(r_x)) << 1)
                 + AW'(r_k);

  assign bus.src_re         = w_re;
  assign bus.src_addr       = w_isWeight ? w_wAddr : w_fAddr;
  assign bus.valid          = (r_count != 2'd0);
  assign bus.data_out       = r_data[r_rdPtr];
  assign bus.beat_is_weight = r_tagW[r_rdPtr];
  assign bus.beat_half      = r_tagH[r_rdPtr];

  assign running = (r_state == LOAD_W) || (r_state == STREAM_F) || (r_state == DRAIN);
  assign done    = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (start) w_nextState = LOAD_W;
      LOAD_W:   if (w_re && r_k) w_nextState = STREAM_F;
      STREAM_F: if (w_re && w_groupEnd) w_nextState = w_lastGroup ? DRAIN : LOAD_W;
      DRAIN:    if ((r_count == 2'd0) && !r_inFlight) w_nextState = DONE;
      DONE:     w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Nested loop counters: k innermost, then y, x, ch_out, ch_in; all wrap to 0.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_k  <= 1'b0;
      r_x  <= '0;
      r_y  <= '0;
      r_ci <= '0;
      r_co <= '0;
    end else if (w_re) begin
      r_k <= ~r_k;
      if (!w_isWeight && r_k) begin
        if (r_y == Y_LAST) begin
          r_y <= '0;
          if (r_x == X_LAST) begin
            r_x <= '0;
            if (r_co == O_LAST) begin
              r_co <= '0;
              r_ci <= (r_ci == I_LAST) ? '0 : r_ci + IW'(1);
            end else begin
              r_co <= r_co + OW'(1);
            end
          end else begin
            r_x <= r_x + XW'(1);
          end
        end else begin
          r_y <= r_y + YW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_inFlight       <= 1'b0;
      r_inFlightWeight <= 1'b0;
      r_inFlightHalf   <= 1'b0;
      r_wrPtr          <= 1'b0;
      r_rdPtr          <= 1'b0;
      r_count          <= 2'd0;
      r_data[0]        <= '0;
      r_data[1]        <= '0;
      r_tagW[0]        <= 1'b0;
      r_tagW[1]        <= 1'b0;
      r_tagH[0]        <= 1'b0;
      r_tagH[1]        <= 1'b0;
    end else begin
      r_inFlight       <= w_re;
      r_inFlightWeight <= w_isWeight;
      r_inFlightHalf   <= r_k;
      if (r_inFlight) begin
        r_data[r_wrPtr] <= bus.src_rdata;
        r_tagW[r_wrPtr] <= r_inFlightWeight;
        r_tagH[r_wrPtr] <= r_inFlightHalf;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, r_inFlight} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Scoreboard bench for conv_stream_feeder: a 2x2x1x2 instance exercises flow control
// and reset, a 1x1x2x1 instance with a weight base checks weight/feature interleave.
module tb_conv_stream_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, startA, runningA, doneA;
  logic rstB, startB, runningB, doneB;

  conv_stream_feeder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(20)) busA ();
  conv_stream_feeder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(20)) busB ();

  conv_stream_feeder #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(2),
    .DATA_WIDTH(16), .LOG2_OF_MEM_HEIGHT(20), .WEIGHT_BASE(0)
  ) dutA (
    .clk(clk), .rst_in(rstA), .start(startA),
    .running(runningA), .done(doneA), .bus(busA)
  );

  conv_stream_feeder #(
    .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1),
    .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(1),
    .DATA_WIDTH(16), .LOG2_OF_MEM_HEIGHT(20), .WEIGHT_BASE(100)
  ) dutB (
    .clk(clk), .rst_in(rstB), .start(startB),
    .running(runningB), .done(doneB), .bus(busB)
  );

  // Memory returns its own address one cycle after a read; junk otherwise.
  always @(posedge clk) begin
    busA.src_rdata <= busA.src_re ? busA.src_addr[15:0] : 16'hdead;
    busB.src_rdata <= busB.src_re ? busB.src_addr[15:0] : 16'hbeef;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [17:0] expQA[$];
  logic [17:0] expQB[$];

  int beatsA = 0, doneCntA = 0, reCntA = 0;
  int firstValidCycA = -1, firstBeatCycA = -1, lastBeatCycA = -1;
  int startCycA = -10;
  int beatsB = 0, doneCntB = 0;
  bit prevStallA = 1'b0;
  logic [17:0] prevPayloadA;
  logic [17:0] payloadA, payloadB;

  assign payloadA = {busA.beat_is_weight, busA.beat_half, busA.data_out};
  assign payloadB = {busB.beat_is_weight, busB.beat_half, busB.data_out};

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic void pushExp(input int inst, input logic [17:0] v);
    if (inst == 0) expQA.push_back(v);
    else           expQB.push_back(v);
  endfunction

  // Reference stream order: per (ch_in, ch_out) a weight pair, then x-major/y-minor feature pairs.
  function automatic void genExp(input int inst, input int w, input int h,
                                 input int nIn, input int nOut, input int base);
    logic [17:0] v;
    for (int ci = 0; ci < nIn; ci++) begin
      for (int co = 0; co < nOut; co++) begin
        for (int k = 0; k < 2; k++) begin
          v = {1'b1, 1'(k), 16'(base + (co * nIn + ci) * 2 + k)};
          pushExp(inst, v);
        end
        for (int x = 0; x < w; x++)
          for (int y = 0; y < h; y++)
            for (int k = 0; k < 2; k++) begin
              v = {1'b0, 1'(k), 16'(((ci * h + y) * w + x) * 2 + k)};
              pushExp(inst, v);
            end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (prevStallA) begin
      checkOutput("stallValidA", 32'(busA.valid), 32'd1);
      if (busA.valid) checkOutput("stallHoldA", 32'(payloadA), 32'(prevPayloadA));
    end
    prevStallA   = busA.valid && !busA.ready && !rstA;
    prevPayloadA = payloadA;

    if (busA.src_re) reCntA++;
    if (busA.valid && firstValidCycA < 0) firstValidCycA = cyc;
    if (cyc == startCycA + 1) checkOutput("runningRiseA", 32'(runningA), 32'd1);
    if (doneA) begin
      doneCntA++;
      checkOutput("validInDoneA", 32'(busA.valid), 32'd0);
    end
    if (busA.valid && busA.ready) begin
      beatsA++;
      if (firstBeatCycA < 0) firstBeatCycA = cyc;
      lastBeatCycA = cyc;
      if (expQA.size() == 0) checkOutput("queueDepthA", 32'(expQA.size()), 32'd1);
      else checkOutput($sformatf("beatA%0d", beatsA), 32'(payloadA), 32'(expQA.pop_front()));
    end

    if (doneB) doneCntB++;
    if (busB.valid && busB.ready) begin
      beatsB++;
      if (expQB.size() == 0) checkOutput("queueDepthB", 32'(expQB.size()), 32'd1);
      else checkOutput($sformatf("beatB%0d", beatsB), 32'(payloadB), 32'(expQB.pop_front()));
    end
  end

  // mode 0: ready high, 1: ready toggles, 2: ready low for 10 cycles then high.
  // extraStartAt >= 0 pulses start again once that many beats have transferred.
  task automatic applyStimulus(input string name, input int mode, input int extraStartAt);
    int  guard;
    bit  pulsed;
    int  reBase;
    beatsA = 0; doneCntA = 0;
    firstValidCycA = -1; firstBeatCycA = -1; lastBeatCycA = -1;
    genExp(0, 2, 2, 1, 2, 0);
    @(posedge clk); #1;
    busA.ready = (mode != 2);
    startA     = 1'b1;
    startCycA  = cyc;
    reBase     = reCntA;
    guard  = 0;
    pulsed = 1'b0;
    while (doneCntA == 0 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
      startA = 1'b0;
      case (mode)
        1:       busA.ready = ~busA.ready;
        2:       busA.ready = (guard >= 10);
        default: busA.ready = 1'b1;
      endcase
      if (extraStartAt >= 0 && !pulsed && beatsA >= extraStartAt) begin
        startA = 1'b1;
        pulsed = 1'b1;
      end
      if (mode == 2 && guard == 9) begin
        @(negedge clk);
        checkOutput({name, "_readsWhileStalled"}, 32'(reCntA - reBase), 32'd2);
        checkOutput({name, "_validWhileStalled"}, 32'(busA.valid), 32'd1);
        checkOutput({name, "_headWhileStalled"}, 32'(payloadA), 32'h20000);
      end
    end
    checkOutput({name, "_doneSeen"}, 32'(doneCntA > 0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput({name, "_firstValid"}, 32'(firstValidCycA - startCycA), 32'd2);
    if (mode == 0)
      checkOutput({name, "_consecutive"}, 32'(lastBeatCycA - firstBeatCycA), 32'd19);
    checkOutput({name, "_beats"}, 32'(beatsA), 32'd20);
    checkOutput({name, "_donePulses"}, 32'(doneCntA), 32'd1);
    checkOutput({name, "_queueLeft"}, 32'(expQA.size()), 32'd0);
    checkOutput({name, "_runningIdle"}, 32'(runningA), 32'd0);
    checkOutput({name, "_validIdle"}, 32'(busA.valid), 32'd0);
  endtask

  initial begin
    int guard;
    int idleBase;
    rstA = 1'b1; rstB = 1'b1;
    startA = 1'b0; startB = 1'b0;
    busA.ready = 1'b0; busB.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstA = 1'b0; rstB = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid",   32'(busA.valid), 32'd0);
    checkOutput("rst_running", 32'(runningA), 32'd0);
    checkOutput("rst_done",    32'(doneA), 32'd0);
    checkOutput("rst_src_re",  32'(busA.src_re), 32'd0);
    checkOutput("rst_data",    32'(busA.data_out), 32'd0);
    checkOutput("rst_isW",     32'(busA.beat_is_weight), 32'd0);
    checkOutput("rst_half",    32'(busA.beat_half), 32'd0);

    applyStimulus("full", 0, -1);
    applyStimulus("toggle", 1, -1);
    applyStimulus("stall", 2, -1);
    applyStimulus("restart", 0, 5);

    // Reset in the middle of a run, then a clean full run.
    beatsA = 0; doneCntA = 0;
    genExp(0, 2, 2, 1, 2, 0);
    @(posedge clk); #1;
    busA.ready = 1'b1;
    startA = 1'b1;
    @(posedge clk); #1;
    startA = 1'b0;
    guard = 0;
    while (beatsA < 7 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("rst_reachBeat7", 32'(beatsA), 32'd7);
    rstA = 1'b1;
    @(posedge clk); #1;
    rstA = 1'b0;
    @(negedge clk);
    checkOutput("midRst_valid",   32'(busA.valid), 32'd0);
    checkOutput("midRst_running", 32'(runningA), 32'd0);
    expQA.delete();
    idleBase = beatsA;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("midRst_noBeats", 32'(beatsA - idleBase), 32'd0);
    checkOutput("midRst_noDone",  32'(doneCntA), 32'd0);
    applyStimulus("afterRst", 0, -1);

    // Second instance: two input channels, one pixel, weight base 100.
    genExp(1, 1, 1, 2, 1, 100);
    @(posedge clk); #1;
    startB = 1'b1;
    @(posedge clk); #1;
    startB = 1'b0;
    guard = 0;
    while (doneCntB == 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("B_doneSeen", 32'(doneCntB > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("B_beats",     32'(beatsB), 32'd8);
    checkOutput("B_queueLeft", 32'(expQB.size()), 32'd0);
    checkOutput("B_donePulses", 32'(doneCntB), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
